// File: rtl/psum_requant_drain.sv
// Drains 32-bit psums from output memory, applies ReLU / rounding shift / int8
// saturation, and packs four results per word onto a valid/ready stream.
module psum_requant_drain #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int BIT_WIDTH  = 8,
  parameter int MEM_DELAY  = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_start,
  input  logic [ADDR_WIDTH-1:0] i_base_addr,
  input  logic [15:0]           i_num_psum,
  input  logic [4:0]            i_shift,
  input  logic                  i_relu_en,
  output logic [ADDR_WIDTH-1:0] mem_radd,
  output logic                  mem_rden,
  input  logic [DATA_WIDTH-1:0] mem_odat,
  input  logic                  mem_ovld,
  output logic [DATA_WIDTH-1:0] o_tdata,
  output logic                  o_tvalid,
  input  logic                  i_tready,
  output logic                  o_tlast,
  output logic                  o_busy,
  output logic                  o_done
);

  localparam int PACK   = DATA_WIDTH / BIT_WIDTH;
  localparam int LANE_W = (PACK > 1) ? $clog2(PACK) : 1;
  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam logic signed [DATA_WIDTH:0] SAT_MAX = (DATA_WIDTH+1)'(2**(BIT_WIDTH-1) - 1);
  localparam logic signed [DATA_WIDTH:0] SAT_MIN = ~SAT_MAX;

  generate
    if (MEM_DELAY < 1 || FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_param_check
      $error("psum_requant_drain: MEM_DELAY must be >= 1 and FIFO_DEPTH a power of 2 >= 2");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   base_q;
  logic [15:0]             num_q;
  logic [4:0]              shift_q;
  logic                    relu_q;
  logic [15:0]             issued_q;
  logic [15:0]             rcvd_q;
  logic [CNT_W-1:0]        outstanding_q;
  logic [LANE_W-1:0]       lane_q;
  logic [DATA_WIDTH-1:0]   pack_q;

  logic [DATA_WIDTH-1:0]   fifo_data [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0]   fifo_last;
  logic [PTR_W-1:0]        wr_ptr, rd_ptr;
  logic [CNT_W-1:0]        fifo_count;

  logic [CNT_W:0]          used;
  logic                    credit_ok;
  logic                    ovld_acc;
  logic                    pop;
  logic                    push;
  logic                    last_psum;
  logic                    lane_full;

  logic signed [DATA_WIDTH-1:0] x;
  logic signed [DATA_WIDTH:0]   r_relu, rnd, r_sum, r_shr;
  logic [BIT_WIDTH-1:0]         q;
  logic [DATA_WIDTH-1:0]        word_next;

  // Credit counts FIFO entries plus psums in flight, so every returning psum has room.
  assign used      = {1'b0, fifo_count} + {1'b0, outstanding_q};
  assign credit_ok = used < (CNT_W+1)'(FIFO_DEPTH);
  assign mem_rden  = (state_q == READ) && credit_ok;
  assign mem_radd  = base_q + ADDR_WIDTH'(issued_q);
  assign ovld_acc  = mem_ovld && (state_q == READ || state_q == DRAIN) && (outstanding_q != '0);
  assign o_tvalid  = (fifo_count != '0);
  assign o_tdata   = fifo_data[rd_ptr];
  assign o_tlast   = o_tvalid && fifo_last[rd_ptr];
  assign pop       = o_tvalid && i_tready;
  assign last_psum = (rcvd_q + 16'd1 == num_q);
  assign lane_full = (lane_q == LANE_W'(PACK - 1));
  assign push      = ovld_acc && (lane_full || last_psum);
  assign o_busy    = (state_q == READ) || (state_q == DRAIN);
  assign o_done    = (state_q == DONE);
  assign x         = $signed(mem_odat);

  // 33-bit datapath: adding the half-LSB to 0x7FFFFFFF cannot overflow.
  always_comb begin
    r_relu = (relu_q && x[DATA_WIDTH-1]) ? '0 : {x[DATA_WIDTH-1], x};
    rnd = '0;
    if (shift_q != 5'd0) rnd[shift_q - 5'd1] = 1'b1;
    r_sum = r_relu + rnd;
    r_shr = r_sum >>> shift_q;
    if (r_shr > SAT_MAX)      q = SAT_MAX[BIT_WIDTH-1:0];
    else if (r_shr < SAT_MIN) q = SAT_MIN[BIT_WIDTH-1:0];
    else                      q = r_shr[BIT_WIDTH-1:0];
    word_next = pack_q;
    word_next[int'(lane_q)*BIT_WIDTH +: BIT_WIDTH] = q;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (i_start) state_d = (i_num_psum == 16'd0) ? DONE : READ;
      READ: if (mem_rden && (issued_q + 16'd1 == num_q)) state_d = DRAIN;
      DRAIN: begin
        if (outstanding_q == '0 && rcvd_q == num_q &&
            (fifo_count == '0 || (fifo_count == CNT_W'(1) && pop)))
          state_d = DONE;
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      base_q        <= '0;
      num_q         <= '0;
      shift_q       <= '0;
      relu_q        <= 1'b0;
      issued_q      <= '0;
      rcvd_q        <= '0;
      outstanding_q <= '0;
      lane_q        <= '0;
      pack_q        <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && i_start) begin
        base_q   <= i_base_addr;
        num_q    <= i_num_psum;
        shift_q  <= i_shift;
        relu_q   <= i_relu_en;
        issued_q <= '0;
        rcvd_q   <= '0;
        lane_q   <= '0;
        pack_q   <= '0;
      end else begin
        issued_q <= issued_q + 16'(mem_rden);
        rcvd_q   <= rcvd_q + 16'(ovld_acc);
        if (ovld_acc) begin
          lane_q <= push ? '0 : lane_q + LANE_W'(1);
          pack_q <= push ? '0 : word_next;
        end
      end
      outstanding_q <= outstanding_q + CNT_W'(mem_rden) - CNT_W'(ovld_acc);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) fifo_data[i] <= '0;
      fifo_last  <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) begin
        fifo_data[wr_ptr] <= word_next;
        fifo_last[wr_ptr] <= last_psum;
        wr_ptr            <= wr_ptr + PTR_W'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
      fifo_count <= fifo_count + CNT_W'(push) - CNT_W'(pop);
    end
  end

endmodule
